// File: rtl/ats_pkg.sv
// ats_pkg: shared definitions for the ATS eligibility-time block.
// Holds the control state encoding, the bit offsets of the fields in the
// eligibility descriptor, and the wrap-safe time comparison helper.
package ats_pkg;

    typedef enum logic [2:0] {
        S_DATA      = 3'd0,
        S_WAIT_FLOW = 3'd1,
        S_CALC      = 3'd2,
        S_UPDATE    = 3'd3,
        S_OUTPUT    = 3'd4
    } atsState_t;

    // Descriptor layout, MSB to LSB: {discard, flow, length, elig_time}
    localparam int ELIG_TIME_LSB = 0;

    function automatic int eligLenLsb(input int timeW);
        return timeW;
    endfunction

    function automatic int eligFlowLsb(input int timeW, input int lenW);
        return timeW + lenW;
    endfunction

    function automatic int eligDiscardBit(input int timeW, input int lenW, input int flowW);
        return timeW + lenW + flowW;
    endfunction

    // True when a is strictly later than b on a w-bit wrapping time line,
    // i.e. the w-bit difference a-b is positive when read as signed.
    function automatic logic time_after(input logic [63:0] a, input logic [63:0] b,
                                        input int unsigned w);
        logic [63:0] mask;
        logic [63:0] signBit;
        logic [63:0] diff;
        mask    = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        signBit = mask & ~(mask >> 1);
        diff    = (a - b) & mask;
        return (diff != 64'd0) && ((diff & signBit) == 64'd0);
    endfunction

endpackage

// File: rtl/ats_flow_state_ram.sv
// ats_flow_state_ram: per-flow bucket-empty timestamps.
// One synchronous write port and one asynchronous read port; the whole
// array is cleared by reset so every flow starts with an empty bucket.
module ats_flow_state_ram #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] memQ [DEPTH];

    // Storage array: cleared on reset, written one entry per cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                memQ[i] <= '0;
            end
        end else if (we) begin
            memQ[waddr] <= wdata;
        end
    end

    assign rdata = memQ[raddr];

endmodule

// File: rtl/ats_eligibility_time.sv
// ats_eligibility_time: passes a byte stream through, measures each frame,
// collects its flow ID and emits an eligibility-time descriptor computed
// with a per-flow token-bucket (ATS) shaper. Flow 0 is never shaped.
// Optional feature: define ATS_MAX_RESIDENCE_EN to flag frames whose
// eligibility time exceeds arrival + cfg_max_residence as discarded.
module ats_eligibility_time
    import ats_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FLOW_NUM   = 16,
    parameter int FLOW_WIDTH = 8,
    parameter int TIME_WIDTH = 32,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [TIME_WIDTH-1:0]              current_time,
    input  logic [FLOW_NUM*16-1:0]             cfg_ns_per_byte,
    input  logic [FLOW_NUM*TIME_WIDTH-1:0]     cfg_burst_ns,
    input  logic [TIME_WIDTH-1:0]              cfg_max_residence,
    input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic                               s_axis_tlast,
    output logic [DATA_WIDTH-1:0]              m_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast,
    input  logic [FLOW_WIDTH-1:0]              s_axis_flow_tdata,
    input  logic                               s_axis_flow_tvalid,
    output logic                               s_axis_flow_tready,
    output logic [1+FLOW_WIDTH+LEN_WIDTH+TIME_WIDTH-1:0] m_axis_elig_tdata,
    output logic                               m_axis_elig_tvalid,
    input  logic                               m_axis_elig_tready
);

    localparam int IDX_W       = (FLOW_NUM > 1) ? $clog2(FLOW_NUM) : 1;
    localparam int PROD_W      = LEN_WIDTH + 16;
    localparam int LEN_LSB     = eligLenLsb(TIME_WIDTH);
    localparam int FLOW_LSB    = eligFlowLsb(TIME_WIDTH, LEN_WIDTH);
    localparam int DISCARD_BIT = eligDiscardBit(TIME_WIDTH, LEN_WIDTH, FLOW_WIDTH);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

    atsState_t stateQ, stateD;

    logic [LEN_WIDTH-1:0]  countQ, countD;
    logic [LEN_WIDTH-1:0]  lengthQ, lengthD;
    logic [TIME_WIDTH-1:0] arrivalQ, arrivalD;
    logic [FLOW_WIDTH-1:0] flowQ, flowD;
    logic [TIME_WIDTH-1:0] eligQ, eligD;
    logic                  discardQ, discardD;

    logic                  beatAccept, flowAccept, eligAccept, flowInRange;
    logic [IDX_W-1:0]      flowIdx;
    logic [15:0]           nsPerByte [FLOW_NUM];
    logic [TIME_WIDTH-1:0] burstNs   [FLOW_NUM];
    logic [TIME_WIDTH-1:0] bucketRd, recovery, sched, full, calcElig, wrData;
    logic                  calcDiscard, wrEn;

    for (genvar f = 0; f < FLOW_NUM; f++) begin : g_cfg
        assign nsPerByte[f] = cfg_ns_per_byte[16*f +: 16];
        assign burstNs[f]   = cfg_burst_ns[TIME_WIDTH*f +: TIME_WIDTH];
    end

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tlast = s_axis_tlast;

    assign beatAccept  = s_axis_tvalid & s_axis_tready;
    assign flowAccept  = s_axis_flow_tvalid & s_axis_flow_tready;
    assign eligAccept  = m_axis_elig_tvalid & m_axis_elig_tready;
    assign flowInRange = ({1'b0, s_axis_flow_tdata} < (FLOW_WIDTH+1)'(FLOW_NUM));
    assign flowIdx     = flowQ[IDX_W-1:0];

    // Shaper arithmetic: every sum wraps modulo 2^TIME_WIDTH
    assign recovery = TIME_WIDTH'(PROD_W'(lengthQ) * PROD_W'(nsPerByte[flowIdx]));
    assign sched    = bucketRd + recovery;
    assign full     = bucketRd + burstNs[flowIdx];
    assign calcElig = (flowQ == '0) ? arrivalQ :
                      (time_after(64'(sched), 64'(arrivalQ), TIME_WIDTH) ? sched : arrivalQ);

`ifdef ATS_MAX_RESIDENCE_EN
    logic [TIME_WIDTH-1:0] residenceLimit;
    assign residenceLimit = arrivalQ + cfg_max_residence;
    assign calcDiscard    = (flowQ != '0) &&
                            time_after(64'(calcElig), 64'(residenceLimit), TIME_WIDTH);
`else
    logic unusedMaxResidence;
    assign unusedMaxResidence = ^cfg_max_residence;
    assign calcDiscard        = 1'b0;
`endif

    // A bucket that has refilled past full only advances by the overshoot
    assign wrEn   = (stateQ == S_UPDATE) && (flowQ != '0) && !discardQ;
    assign wrData = time_after(64'(full), 64'(eligQ), TIME_WIDTH) ? eligQ
                                                                   : bucketRd + (eligQ - full);

    ats_flow_state_ram #(
        .DEPTH  (FLOW_NUM),
        .WIDTH  (TIME_WIDTH),
        .ADDR_W (IDX_W)
    ) u_flow_state (
        .clk   (clk),
        .rstn  (rstn),
        .we    (wrEn),
        .waddr (flowIdx),
        .wdata (wrData),
        .raddr (flowIdx),
        .rdata (bucketRd)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stateQ <= S_DATA;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state: data, flow ID, two compute cycles, then hold the descriptor
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            S_DATA:      if (beatAccept && s_axis_tlast) stateD = S_WAIT_FLOW;
            S_WAIT_FLOW: if (flowAccept) stateD = S_CALC;
            S_CALC:      stateD = S_UPDATE;
            S_UPDATE:    stateD = S_OUTPUT;
            S_OUTPUT:    if (eligAccept) stateD = S_DATA;
            default:     stateD = S_DATA;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        s_axis_tready      = 1'b0;
        m_axis_tvalid      = 1'b0;
        s_axis_flow_tready = 1'b0;
        m_axis_elig_tvalid = 1'b0;
        unique case (stateQ)
            S_DATA: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
            end
            S_WAIT_FLOW: s_axis_flow_tready = 1'b1;
            S_OUTPUT:    m_axis_elig_tvalid = 1'b1;
            default:     ;
        endcase
    end

    // Frame bookkeeping: beat count, latched length/arrival/flow and result
    always_comb begin
        countD   = countQ;
        lengthD  = lengthQ;
        arrivalD = arrivalQ;
        flowD    = flowQ;
        eligD    = eligQ;
        discardD = discardQ;
        unique case (stateQ)
            S_DATA: begin
                if (beatAccept) begin
                    if (s_axis_tlast) begin
                        lengthD  = (countQ == LEN_MAX) ? LEN_MAX : countQ + 1'b1;
                        arrivalD = current_time;
                        countD   = '0;
                    end else begin
                        countD = (countQ == LEN_MAX) ? LEN_MAX : countQ + 1'b1;
                    end
                end
            end
            S_WAIT_FLOW: if (flowAccept) flowD = flowInRange ? s_axis_flow_tdata : '0;
            S_CALC: begin
                eligD    = calcElig;
                discardD = calcDiscard;
            end
            default: ;
        endcase
    end

    // Frame bookkeeping registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            countQ   <= '0;
            lengthQ  <= '0;
            arrivalQ <= '0;
            flowQ    <= '0;
            eligQ    <= '0;
            discardQ <= 1'b0;
        end else begin
            countQ   <= countD;
            lengthQ  <= lengthD;
            arrivalQ <= arrivalD;
            flowQ    <= flowD;
            eligQ    <= eligD;
            discardQ <= discardD;
        end
    end

    assign m_axis_elig_tdata[DISCARD_BIT]                = discardQ;
    assign m_axis_elig_tdata[FLOW_LSB +: FLOW_WIDTH]     = flowQ;
    assign m_axis_elig_tdata[LEN_LSB +: LEN_WIDTH]       = lengthQ;
    assign m_axis_elig_tdata[ELIG_TIME_LSB +: TIME_WIDTH] = eligQ;

endmodule

// File: tb/tb_ats_eligibility_time.sv
// tb_ats_eligibility_time: directed and randomized frames checked against
// a token-bucket reference model. Honours ATS_MAX_RESIDENCE_EN if defined.
`timescale 1ns/1ps
module tb_ats_eligibility_time;

    localparam int DATA_WIDTH = 8;
    localparam int FLOW_NUM   = 16;
    localparam int FLOW_WIDTH = 8;
    localparam int TIME_WIDTH = 32;
    localparam int LEN_WIDTH  = 11;
    localparam int ELIG_W     = 1 + FLOW_WIDTH + LEN_WIDTH + TIME_WIDTH;

    logic                            clk = 1'b0;
    logic                            rstn;
    logic [TIME_WIDTH-1:0]           current_time;
    logic [FLOW_NUM*16-1:0]          cfg_ns_per_byte;
    logic [FLOW_NUM*TIME_WIDTH-1:0]  cfg_burst_ns;
    logic [TIME_WIDTH-1:0]           cfg_max_residence;
    logic [DATA_WIDTH-1:0]           s_axis_tdata;
    logic                            s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [DATA_WIDTH-1:0]           m_axis_tdata;
    logic                            m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [FLOW_WIDTH-1:0]           s_axis_flow_tdata;
    logic                            s_axis_flow_tvalid, s_axis_flow_tready;
    logic [ELIG_W-1:0]               m_axis_elig_tdata;
    logic                            m_axis_elig_tvalid, m_axis_elig_tready;

    int vecCount = 0;
    int errCount = 0;

    // Reference model state and configuration
    logic [31:0] refBucket [FLOW_NUM];
    logic [15:0] refNs     [FLOW_NUM];
    logic [31:0] refBurst  [FLOW_NUM];
    logic [31:0] refMaxRes;

    ats_eligibility_time #(
        .DATA_WIDTH (DATA_WIDTH),
        .FLOW_NUM   (FLOW_NUM),
        .FLOW_WIDTH (FLOW_WIDTH),
        .TIME_WIDTH (TIME_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .current_time       (current_time),
        .cfg_ns_per_byte    (cfg_ns_per_byte),
        .cfg_burst_ns       (cfg_burst_ns),
        .cfg_max_residence  (cfg_max_residence),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tlast       (s_axis_tlast),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .m_axis_tlast       (m_axis_tlast),
        .s_axis_flow_tdata  (s_axis_flow_tdata),
        .s_axis_flow_tvalid (s_axis_flow_tvalid),
        .s_axis_flow_tready (s_axis_flow_tready),
        .m_axis_elig_tdata  (m_axis_elig_tdata),
        .m_axis_elig_tvalid (m_axis_elig_tvalid),
        .m_axis_elig_tready (m_axis_elig_tready)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Safety net in case the run stops making progress
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish, observed running, expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sAfter(input logic [31:0] a, input logic [31:0] b);
        return $signed(a - b) > 0;
    endfunction

    task automatic applyConfig();
        for (int f = 0; f < FLOW_NUM; f++) begin
            cfg_ns_per_byte[16*f +: 16] = refNs[f];
            cfg_burst_ns[32*f +: 32]    = refBurst[f];
        end
        cfg_max_residence = refMaxRes;
    endtask

    // Reference: eligibility descriptor for one frame, updating bucket state
    task automatic refFrame(input int flowRaw, input int len, input logic [31:0] tArr,
                            output logic [ELIG_W-1:0] expWord);
        int          f;
        logic [10:0] lenEff;
        longint      prod;
        logic [31:0] rec, sched, full, elig;
        logic        disc;
        f      = (flowRaw >= FLOW_NUM) ? 0 : flowRaw;
        lenEff = (len > 2047) ? 11'd2047 : 11'(len);
        elig   = tArr;
        disc   = 1'b0;
        if (f != 0) begin
            prod  = longint'(lenEff) * longint'(refNs[f]);
            rec   = prod[31:0];
            sched = refBucket[f] + rec;
            full  = refBucket[f] + refBurst[f];
            elig  = sAfter(sched, tArr) ? sched : tArr;
`ifdef ATS_MAX_RESIDENCE_EN
            disc  = sAfter(elig, tArr + refMaxRes);
`endif
            if (!disc) begin
                refBucket[f] = sAfter(full, elig) ? elig : refBucket[f] + (elig - full);
            end
        end
        expWord = {disc, 8'(f), lenEff, elig};
    endtask

    task automatic sendBeats(input int len, input logic [31:0] tArr);
        int waitCnt;
        for (int i = 0; i < len; i++) begin
            s_axis_tdata  = 8'($urandom);
            s_axis_tlast  = (i == len - 1);
            s_axis_tvalid = 1'b1;
            current_time  = tArr - 32'(len - 1 - i);
            #1;
            waitCnt = 0;
            while (!s_axis_tready && waitCnt < 50) begin
                @(negedge clk);
                #1;
                waitCnt++;
            end
            if (waitCnt >= 50) checkOutput("beatReadyTimeout", 64'(s_axis_tready), 64'd1);
            if (i == len - 1) begin
                checkOutput("dataPassThrough", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                            {1'b1, 1'b1, s_axis_tdata});
            end
            @(posedge clk);
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic sendFlow(input int flowRaw);
        s_axis_flow_tdata  = 8'(flowRaw);
        s_axis_flow_tvalid = 1'b1;
        #1;
        checkOutput("flowReady", 64'(s_axis_flow_tready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        s_axis_flow_tvalid = 1'b0;
    endtask

    task automatic awaitElig(input logic [ELIG_W-1:0] expWord, input int stall,
                             output logic [ELIG_W-1:0] obsWord);
        int lat;
        checkOutput("dataBlockedInCalc", 64'(s_axis_tready), 64'd0);
        lat = 0;
        while (!m_axis_elig_tvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("eligLatency", 64'(lat), 64'd2);
        obsWord = m_axis_elig_tdata;
        checkOutput("eligWord", 64'(obsWord), 64'(expWord));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput("stallHold", {m_axis_elig_tvalid, s_axis_tready, m_axis_elig_tdata},
                        {1'b1, 1'b0, expWord});
        end
        m_axis_elig_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_axis_elig_tready = 1'b0;
        checkOutput("afterEligHandshake", {m_axis_elig_tvalid, s_axis_tready}, 2'b01);
    endtask

    task automatic applyStimulus(input int len, input int flowRaw, input logic [31:0] tArr,
                                 input int stall, output logic [ELIG_W-1:0] obsWord);
        logic [ELIG_W-1:0] expWord;
        refFrame(flowRaw, len, tArr, expWord);
        sendBeats(len, tArr);
        checkOutput("holdAfterLast", {s_axis_tready, s_axis_flow_tready}, 2'b01);
        sendFlow(flowRaw);
        awaitElig(expWord, stall, obsWord);
    endtask

    // Directed scenarios first, then randomized frames against the model
    initial begin
        logic [ELIG_W-1:0] obs;
        logic [31:0]       tNow;
        int                seen;

        rstn               = 1'b0;
        current_time       = '0;
        s_axis_tdata       = '0;
        s_axis_tvalid      = 1'b0;
        s_axis_tlast       = 1'b0;
        m_axis_tready      = 1'b1;
        s_axis_flow_tdata  = '0;
        s_axis_flow_tvalid = 1'b0;
        m_axis_elig_tready = 1'b0;

        for (int f = 0; f < FLOW_NUM; f++) begin
            refBucket[f] = '0;
            refNs[f]     = 16'($urandom_range(0, 40));
            refBurst[f]  = 32'($urandom_range(0, 5000));
        end
        refNs[0]    = 16'd7;
        refBurst[0] = 32'd100;
        refNs[1]    = 16'd8;  refBurst[1] = 32'd10000;
        refNs[2]    = 16'd8;  refBurst[2] = 32'h200;
        refNs[3]    = 16'd8;  refBurst[3] = 32'd100000;
        refMaxRes   = 32'd1000000;
        applyConfig();

        repeat (3) @(negedge clk);
        checkOutput("resetOutputs",
                    {s_axis_flow_tready, m_axis_elig_tvalid, m_axis_tvalid, m_axis_elig_tdata},
                    '0);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("idleReady", {s_axis_tready, s_axis_flow_tready, m_axis_elig_tvalid}, 3'b100);
        m_axis_tready = 1'b0;
        #1;
        checkOutput("readyFollowsDownstream", 64'(s_axis_tready), 64'd0);
        m_axis_tready = 1'b1;
        @(negedge clk);

        $display("[TB] unshaped flow 0 frame");
        applyStimulus(64, 0, 32'd1000, 0, obs);
        checkOutput("flow0Descriptor", 64'(obs), 64'({1'b0, 8'd0, 11'd64, 32'd1000}));

        $display("[TB] flow 1 conformant then shaped");
        applyStimulus(100, 1, 32'd5000, 0, obs);
        checkOutput("flow1First", 64'(obs[31:0]), 64'd5000);
        applyStimulus(100, 1, 32'd5100, 0, obs);
        checkOutput("flow1Second", 64'(obs[31:0]), 64'd5800);

        $display("[TB] out-of-range flow ID");
        applyStimulus(20, 20, 32'd7000, 0, obs);
        checkOutput("flowOutOfRange", {obs[50:43], obs[31:0]}, {8'd0, 32'd7000});

        $display("[TB] descriptor backpressure");
        applyStimulus(8, 0, 32'd8000, 10, obs);

        $display("[TB] wrap-around of the time line");
        applyStimulus(16, 2, 32'h7000_0000, 0, obs);
        applyStimulus(16, 2, 32'hE000_0000, 0, obs);
        applyStimulus(16, 2, 32'hFFFF_FE00, 0, obs);
        applyStimulus(160, 2, 32'hFFFF_FF00, 0, obs);
        checkOutput("wrapElig", 64'(obs[31:0]), 64'h0000_0100);

        $display("[TB] max residence");
        refMaxRes = 32'd100;
        applyConfig();
        applyStimulus(100, 3, 32'd0, 0, obs);
`ifdef ATS_MAX_RESIDENCE_EN
        checkOutput("residenceDiscard", {obs[51], obs[31:0]}, {1'b1, 32'd800});
        applyStimulus(100, 3, 32'd10, 0, obs);
        checkOutput("residenceNoUpdate", 64'(obs[31:0]), 64'd800);
`else
        checkOutput("residenceDiscard", {obs[51], obs[31:0]}, {1'b0, 32'd800});
        applyStimulus(100, 3, 32'd10, 0, obs);
        checkOutput("residenceNoUpdate", 64'(obs[31:0]), 64'd1600);
`endif
        refMaxRes = 32'd1000000;
        applyConfig();

        $display("[TB] length saturation");
        applyStimulus(2050, 0, 32'd9000, 0, obs);
        checkOutput("lenSaturate", 64'(obs[42:32]), 64'd2047);

        $display("[TB] reset during calculation");
        sendBeats(10, 32'd9500);
        sendFlow(1);
        rstn = 1'b0;
        #1;
        checkOutput("resetAbandon", {m_axis_elig_tvalid, s_axis_flow_tready, m_axis_elig_tdata}, '0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (m_axis_elig_tvalid) seen++;
        end
        checkOutput("noEligAfterReset", 64'(seen), 64'd0);
        for (int f = 0; f < FLOW_NUM; f++) refBucket[f] = '0;
        applyStimulus(100, 1, 32'd6000, 0, obs);
        checkOutput("bucketCleared", 64'(obs[31:0]), 64'd6000);

        $display("[TB] randomized frames");
        tNow = 32'd30000;
        for (int n = 0; n < 25; n++) begin
            tNow = tNow + 32'($urandom_range(0, 1500));
            applyStimulus($urandom_range(1, 40), $urandom_range(0, 19), tNow,
                          $urandom_range(0, 2), obs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/ats_eligibility_time.md
ATS_ELIGIBILITY_TIME -- requirements
Module: ats_eligibility_time

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, stream data width in bits (one byte per beat).
REQ-002 SHALL have parameter FLOW_NUM, default 16, number of flow IDs; flow 0 is the default unshaped flow.
REQ-003 SHALL have parameter FLOW_WIDTH, default 8, flow ID width.
REQ-004 SHALL have parameter TIME_WIDTH, default 32, nanosecond timestamp width.
REQ-005 SHALL have parameter LEN_WIDTH, default 11, frame byte-count width.
REQ-006 SHALL use one clock, clk; reset rstn is asynchronous and active-low.
REQ-007 SHALL have ports: clk in 1, clock; rstn in 1, async active-low reset.
REQ-008 current_time in TIME_WIDTH, free-running ns counter, wraps modulo 2^TIME_WIDTH.
REQ-009 cfg_ns_per_byte in FLOW_NUM*16, per-flow inverse committed rate; slice f is [16f+15:16f].
REQ-010 cfg_burst_ns in FLOW_NUM*TIME_WIDTH, per-flow emptyToFullDuration (CBS/CIR).
REQ-011 cfg_max_residence in TIME_WIDTH, max residence time; used only with ATS_MAX_RESIDENCE_EN.
REQ-012 s_axis_tdata/tvalid/tready/tlast: frame data in; m_axis_tdata/tvalid/tready/tlast: frame data out.
REQ-013 s_axis_flow_tdata in FLOW_WIDTH, s_axis_flow_tvalid in 1, s_axis_flow_tready out 1: flow ID, one per frame, arriving after that frame's tlast.
REQ-014 m_axis_elig_tdata out 1+FLOW_WIDTH+LEN_WIDTH+TIME_WIDTH, packed MSB-to-LSB {discard, flow, length, elig_time}; m_axis_elig_tvalid out 1, m_axis_elig_tready in 1.

Function
REQ-015 Data path combinational: m_axis_tdata/tlast = s_axis_*; m_axis_tvalid = s_axis_tvalid & state==S_DATA; s_axis_tready = m_axis_tready & state==S_DATA.
REQ-016 In S_DATA, count accepted beats; on accepted tlast, latch length = count+1 (saturate at 2^LEN_WIDTH-1), latch arrival = current_time, go to S_WAIT_FLOW, clear count.
REQ-017 S_WAIT_FLOW: s_axis_flow_tready=1; on handshake latch flow ID (ID >= FLOW_NUM mapped to 0), go to S_CALC.
REQ-018 S_CALC (1 cycle): recovery = length*ns_per_byte[flow] truncated to TIME_WIDTH; sched = bucket_empty[flow]+recovery; full = bucket_empty[flow]+burst[flow]; all sums modulo 2^TIME_WIDTH.
REQ-019 elig = later of arrival and sched, compared by signed (TIME_WIDTH-bit) difference so wrap-around orders correctly.
REQ-020 Flow 0: elig = arrival, discard=0, no per-flow state update.
REQ-021 S_UPDATE (1 cycle), flow!=0 and discard=0: bucket_empty[flow] = elig if elig earlier than full, else bucket_empty[flow]+(elig-full); discard=1 leaves state unchanged.
REQ-022 S_OUTPUT: m_axis_elig_tvalid=1, tdata stable until m_axis_elig_tready; then return to S_DATA.
REQ-023 Latency tlast acceptance to elig tvalid: flow handshake + 2 cycles; no new data accepted until elig handshake completes.
REQ-024 Back-to-back frames: first beat of next frame may be accepted the cycle after elig handshake.

Reset
REQ-025 On rstn low: state=S_DATA, count=0, all bucket_empty=0, latched length/flow/arrival/elig/discard=0, all tvalid=0, s_axis_flow_tready=0.
REQ-026 Reset mid-frame or mid-calculation SHALL abandon the frame with no elig output.

Configuration
REQ-027 Macro ATS_MAX_RESIDENCE_EN defined: discard=1 when elig is later than arrival+cfg_max_residence (signed-difference compare).
REQ-028 Macro undefined: discard tied 0, cfg_max_residence ignored; the port remains.

Structure
REQ-029 Shared package ats_pkg SHALL hold state encodings, elig tdata field offsets and a time_after(a,b) signed-difference helper.
REQ-030 Per-flow bucket_empty storage SHALL be a sub-module ats_flow_state_ram (FLOW_NUM x TIME_WIDTH, 1 read/1 write port, synchronous write, async read).

Verification
REQ-031 Reset, 64-byte frame flow 0 at current_time=1000 -> elig {0,0,64,1000}.
REQ-032 Flow 1, ns_per_byte=8, burst=10000, bucket_empty=0, 100-byte frame at t=5000 -> elig=5000; then second 100-byte frame at t=5100 -> sched=5800, elig=5800.
REQ-033 Flow ID 20 with FLOW_NUM=16 -> reported flow 0, elig=arrival.
REQ-034 current_time near 0xFFFF_FF00, flow 2, sched wraps to 0x0000_0100 -> elig=0x0000_0100 (later), not arrival.
REQ-035 With ATS_MAX_RESIDENCE_EN, max_residence=100, elig-arrival=800 -> discard=1 and next same-flow frame sees unchanged bucket_empty; without macro -> discard=0.
REQ-036 m_axis_elig_tready held low 10 cycles -> tdata stable, s_axis_tready=0 throughout, next frame accepted after handshake.
